// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_pkg
//  Purpose  : Shared types for the RV32 memory stage: the access-width
//             encoding, the memory FSM state type and a width decode helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  // Access width as carried on mem_width_in; encoding 3 is reserved.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } width_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // The reserved encoding behaves exactly like a word access.
  function automatic width_e decode_width(input logic [1:0] raw);
    case (raw)
      2'd0:    decode_width = BYTE;
      2'd1:    decode_width = HALF;
      default: decode_width = WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_mem_align.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_mem_align
//  Purpose  : Combinational load formatter. Picks the byte or halfword lane
//             out of the bus word using the low address bits, then sign- or
//             zero-extends it to 32 bits.
//  Ports    : read_value   in  32  raw word returned by the bus
//             width        in  2   access width (width_e)
//             zero_extend  in  1   zero-extend instead of sign-extend
//             addr_lo      in  2   low address bits of the access
//             load_value   out 32  formatted writeback value
//  Revision : 1.0 - initial release
// ============================================================================
module rv32_mem_align
  import rv32_pkg::*;
(
  input  logic [31:0] read_value,
  input  width_e      width,
  input  logic        zero_extend,
  input  logic [1:0]  addr_lo,
  output logic [31:0] load_value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = read_value[7:0];
    case (addr_lo)
      2'd0: byte_lane = read_value[7:0];
      2'd1: byte_lane = read_value[15:8];
      2'd2: byte_lane = read_value[23:16];
      2'd3: byte_lane = read_value[31:24];
      default: byte_lane = read_value[7:0];
    endcase

    // Halfword lane ignores addr_lo[0]; a misaligned half reads its aligned pair.
    half_lane = addr_lo[1] ? read_value[31:16] : read_value[15:0];

    case (width)
      BYTE:    load_value = {{24{~zero_extend & byte_lane[7]}}, byte_lane};
      HALF:    load_value = {{16{~zero_extend & half_lane[15]}}, half_lane};
      default: load_value = read_value;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32_mem.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_mem
//  Purpose  : RV32 memory stage. Non-memory results pass through to the
//             writeback registers in one cycle; loads and stores issue a
//             single bus access and stall upstream until the bus is ready.
//  Ports    : clk, reset_n (async, active low)
//             mem_read_en_in, mem_write_en_in, mem_width_in,
//             mem_zero_extend_in, rd_in, rd_writeback_in, result_in,
//             rs2_value_in                      - execute-stage inputs
//             bus_address_out, bus_read_out, bus_write_out,
//             bus_write_mask_out, bus_write_value_out,
//             bus_read_value_in, bus_ready_in   - memory bus
//             stall_out                         - upstream hold
//             rd_out, rd_writeback_out, rd_value_out - writeback stage
//             misaligned_out (only with RV32_MEM_ALIGN_CHECK_EN)
//  Config   : RV32_MEM_ALIGN_CHECK_EN - reject misaligned half/word accesses
//             and flag them on misaligned_out.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32_mem
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_writeback_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in,
  output logic        stall_out,
  output logic [4:0]  rd_out,
  output logic        rd_writeback_out,
  output logic [31:0] rd_value_out
`ifdef RV32_MEM_ALIGN_CHECK_EN
  ,
  output logic        misaligned_out
`endif
);

  state_e      state;
  state_e      state_next;
  width_e      req_width;
  width_e      lat_width;
  logic        lat_zext;
  logic [1:0]  lat_addr_lo;
  logic        lat_wb;
  logic        mem_req;
  logic        misaligned;
  logic        accept;
  logic [3:0]  store_mask;
  logic [31:0] store_data;
  logic [31:0] load_value;

  assign req_width = decode_width(mem_width_in);
  assign mem_req   = mem_read_en_in | mem_write_en_in;

`ifdef RV32_MEM_ALIGN_CHECK_EN
  assign misaligned = mem_req &&
                      (((req_width == HALF) && result_in[0]) ||
                       ((req_width == WORD) && (result_in[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign accept    = (state == IDLE) && mem_req && !misaligned;
  assign stall_out = (state == BUSY) && !bus_ready_in;

  // Store lanes: data replicated so every enabled lane carries the value.
  always_comb begin
    store_mask = 4'b1111;
    store_data = rs2_value_in;
    case (req_width)
      BYTE: begin
        store_mask = 4'b0001 << result_in[1:0];
        store_data = {4{rs2_value_in[7:0]}};
      end
      HALF: begin
        store_mask = 4'b0011 << {result_in[1], 1'b0};
        store_data = {2{rs2_value_in[15:0]}};
      end
      default: begin
        store_mask = 4'b1111;
        store_data = rs2_value_in;
      end
    endcase
  end

  rv32_mem_align u_align (
    .read_value  (bus_read_value_in),
    .width       (lat_width),
    .zero_extend (lat_zext),
    .addr_lo     (lat_addr_lo),
    .load_value  (load_value)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (bus_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_address_out     <= '0;
      bus_read_out        <= 1'b0;
      bus_write_out       <= 1'b0;
      bus_write_mask_out  <= '0;
      bus_write_value_out <= '0;
      rd_out              <= '0;
      rd_writeback_out    <= 1'b0;
      rd_value_out        <= '0;
      lat_width           <= BYTE;
      lat_zext            <= 1'b0;
      lat_addr_lo         <= '0;
      lat_wb              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Read wins over write; a read carries no write lanes.
            bus_address_out     <= {result_in[31:2], 2'b00};
            bus_read_out        <= mem_read_en_in;
            bus_write_out       <= mem_write_en_in & ~mem_read_en_in;
            bus_write_mask_out  <= mem_read_en_in ? 4'b0000 : store_mask;
            bus_write_value_out <= mem_read_en_in ? 32'd0 : store_data;
            rd_out              <= rd_in;
            rd_writeback_out    <= 1'b0;
            lat_width           <= req_width;
            lat_zext            <= mem_zero_extend_in;
            lat_addr_lo         <= result_in[1:0];
            lat_wb              <= rd_writeback_in;
          end else if (mem_req) begin
            // Rejected misaligned access: nothing retires.
            rd_writeback_out <= 1'b0;
          end else begin
            rd_out           <= rd_in;
            rd_writeback_out <= rd_writeback_in;
            rd_value_out     <= result_in;
          end
        end
        BUSY: begin
          rd_writeback_out <= 1'b0;
          if (bus_ready_in) begin
            bus_read_out  <= 1'b0;
            bus_write_out <= 1'b0;
            // bus_read_out still identifies the in-flight op as a load here.
            if (bus_read_out) begin
              rd_value_out     <= load_value;
              rd_writeback_out <= lat_wb;
            end
          end
        end
        default: rd_writeback_out <= 1'b0;
      endcase
    end
  end

`ifdef RV32_MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misaligned_out <= 1'b0;
    else          misaligned_out <= (state == IDLE) && misaligned;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32_mem
//  Purpose  : Directed self-checking bench for rv32_mem. Each task drives one
//             scenario and compares outputs against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rv32_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read_en_in, mem_write_en_in;
  logic [1:0]  mem_width_in;
  logic        mem_zero_extend_in;
  logic [4:0]  rd_in;
  logic        rd_writeback_in;
  logic [31:0] result_in, rs2_value_in;
  logic [31:0] bus_address_out;
  logic        bus_read_out, bus_write_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;
  logic        stall_out;
  logic [4:0]  rd_out;
  logic        rd_writeback_out;
  logic [31:0] rd_value_out;
`ifdef RV32_MEM_ALIGN_CHECK_EN
  logic        misaligned_out;
`endif

  int checks = 0;
  int failures = 0;

  rv32_mem dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .mem_read_en_in      (mem_read_en_in),
    .mem_write_en_in     (mem_write_en_in),
    .mem_width_in        (mem_width_in),
    .mem_zero_extend_in  (mem_zero_extend_in),
    .rd_in               (rd_in),
    .rd_writeback_in     (rd_writeback_in),
    .result_in           (result_in),
    .rs2_value_in        (rs2_value_in),
    .bus_address_out     (bus_address_out),
    .bus_read_out        (bus_read_out),
    .bus_write_out       (bus_write_out),
    .bus_write_mask_out  (bus_write_mask_out),
    .bus_write_value_out (bus_write_value_out),
    .bus_read_value_in   (bus_read_value_in),
    .bus_ready_in        (bus_ready_in),
    .stall_out           (stall_out),
    .rd_out              (rd_out),
    .rd_writeback_out    (rd_writeback_out),
    .rd_value_out        (rd_value_out)
`ifdef RV32_MEM_ALIGN_CHECK_EN
    ,
    .misaligned_out      (misaligned_out)
`endif
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_en_in     = 1'b0;
    mem_write_en_in    = 1'b0;
    mem_width_in       = 2'd0;
    mem_zero_extend_in = 1'b0;
    rd_in              = 5'd0;
    rd_writeback_in    = 1'b0;
    result_in          = 32'd0;
    rs2_value_in       = 32'd0;
    bus_read_value_in  = 32'd0;
    bus_ready_in       = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    result_in       = 32'h5555_AAAA;
    rd_in           = 5'd3;
    rd_writeback_in = 1'b1;
    step();
    step();
    checks++;
    if ({bus_read_out, bus_write_out, bus_write_mask_out, stall_out} !== 7'd0) begin
      failures++;
      $display("FAIL reset_bus_ctrl: got rd=%b wr=%b mask=%b stall=%b required all 0",
               bus_read_out, bus_write_out, bus_write_mask_out, stall_out);
    end
    checks++;
    if ({bus_address_out, bus_write_value_out} !== 64'd0) begin
      failures++;
      $display("FAIL reset_bus_data: got addr=%h wval=%h required 0", bus_address_out, bus_write_value_out);
    end
    checks++;
    if ({rd_out, rd_writeback_out, rd_value_out} !== 38'd0) begin
      failures++;
      $display("FAIL reset_wb: got rd=%0d wb=%b val=%h required 0", rd_out, rd_writeback_out, rd_value_out);
    end
    idle_inputs();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_nonmem();
    idle_inputs();
    result_in       = 32'h0000_1234;
    rd_in           = 5'd5;
    rd_writeback_in = 1'b1;
    step();
    checks++;
    if ({rd_value_out, rd_out, rd_writeback_out} !== {32'h0000_1234, 5'd5, 1'b1}) begin
      failures++;
      $display("FAIL nonmem_wb: got val=%h rd=%0d wb=%b required 00001234/5/1",
               rd_value_out, rd_out, rd_writeback_out);
    end
    checks++;
    if ({bus_read_out, bus_write_out, stall_out} !== 3'b000) begin
      failures++;
      $display("FAIL nonmem_bus: got rd=%b wr=%b stall=%b required 000", bus_read_out, bus_write_out, stall_out);
    end
  endtask

  task automatic test_byte_load(input logic zext, input logic [31:0] exp_val);
    idle_inputs();
    mem_read_en_in     = 1'b1;
    mem_width_in       = 2'd0;
    mem_zero_extend_in = zext;
    result_in          = 32'h0000_0103;
    rd_in              = 5'd7;
    rd_writeback_in    = 1'b1;
    bus_read_value_in  = 32'h80AA_BBCC;
    bus_ready_in       = 1'b1;
    step();
    checks++;
    if ({bus_address_out, bus_read_out, bus_write_out, rd_writeback_out} !== {32'h0000_0100, 3'b100}) begin
      failures++;
      $display("FAIL byte_load_req: got addr=%h rd=%b wr=%b wb=%b required 00000100/1/0/0",
               bus_address_out, bus_read_out, bus_write_out, rd_writeback_out);
    end
    mem_read_en_in  = 1'b0;
    rd_writeback_in = 1'b0;
    result_in       = 32'd0;
    rd_in           = 5'd0;
    step();
    checks++;
    if ({rd_value_out, rd_out, rd_writeback_out, bus_read_out} !== {exp_val, 5'd7, 2'b10}) begin
      failures++;
      $display("FAIL byte_load_done zext=%b: got val=%h rd=%0d wb=%b brd=%b required %h/7/1/0",
               zext, rd_value_out, rd_out, rd_writeback_out, bus_read_out, exp_val);
    end
  endtask

  task automatic test_store(input logic [1:0] width, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_addr, input logic [3:0] exp_mask, input logic [31:0] exp_val);
    idle_inputs();
    mem_write_en_in = 1'b1;
    mem_width_in    = width;
    result_in       = addr;
    rs2_value_in    = data;
    rd_in           = 5'd4;
    rd_writeback_in = 1'b1;
    bus_ready_in    = 1'b0;
    step();
    checks++;
    if ({bus_address_out, bus_write_mask_out, bus_write_value_out} !== {exp_addr, exp_mask, exp_val}) begin
      failures++;
      $display("FAIL store_lanes w=%0d: got addr=%h mask=%b val=%h required %h/%b/%h",
               width, bus_address_out, bus_write_mask_out, bus_write_value_out, exp_addr, exp_mask, exp_val);
    end
    checks++;
    if ({bus_write_out, bus_read_out, rd_writeback_out, stall_out} !== 4'b1001) begin
      failures++;
      $display("FAIL store_req w=%0d: got wr=%b rd=%b wb=%b stall=%b required 1/0/0/1",
               width, bus_write_out, bus_read_out, rd_writeback_out, stall_out);
    end
    idle_inputs();
    bus_ready_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL store_ready_stall: got %b required 0", stall_out);
    end
    step();
    checks++;
    if ({bus_write_out, rd_writeback_out} !== 2'b00) begin
      failures++;
      $display("FAIL store_done: got wr=%b wb=%b required 0/0", bus_write_out, rd_writeback_out);
    end
  endtask

  task automatic test_word_load_wait();
    idle_inputs();
    mem_read_en_in    = 1'b1;
    mem_width_in      = 2'd2;
    result_in         = 32'h0000_0040;
    rd_in             = 5'd9;
    rd_writeback_in   = 1'b1;
    bus_ready_in      = 1'b0;
    bus_read_value_in = 32'hDEAD_BEEF;
    step();
    mem_read_en_in  = 1'b0;
    rd_writeback_in = 1'b0;
    result_in       = 32'h0000_0999;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({stall_out, bus_read_out, bus_address_out, rd_writeback_out} !== {2'b11, 32'h0000_0040, 1'b0}) begin
        failures++;
        $display("FAIL wait_cycle%0d: got stall=%b rd=%b addr=%h wb=%b required 1/1/00000040/0",
                 i, stall_out, bus_read_out, bus_address_out, rd_writeback_out);
      end
      if (i < 2) step();
    end
    bus_ready_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL wait_ready_stall: got %b required 0", stall_out);
    end
    step();
    checks++;
    if ({rd_value_out, rd_out, rd_writeback_out, bus_read_out} !== {32'hDEAD_BEEF, 5'd9, 2'b10}) begin
      failures++;
      $display("FAIL wait_done: got val=%h rd=%0d wb=%b brd=%b required deadbeef/9/1/0",
               rd_value_out, rd_out, rd_writeback_out, bus_read_out);
    end
  endtask

  task automatic test_read_priority();
    idle_inputs();
    mem_read_en_in    = 1'b1;
    mem_write_en_in   = 1'b1;
    mem_width_in      = 2'd1;
    result_in         = 32'h0000_0012;
    rs2_value_in      = 32'h1111_2222;
    rd_in             = 5'd11;
    rd_writeback_in   = 1'b1;
    bus_read_value_in = 32'h8001_1234;
    step();
    checks++;
    if ({bus_read_out, bus_write_out, bus_address_out} !== {2'b10, 32'h0000_0010}) begin
      failures++;
      $display("FAIL priority_req: got rd=%b wr=%b addr=%h required 1/0/00000010",
               bus_read_out, bus_write_out, bus_address_out);
    end
    idle_inputs();
    bus_read_value_in = 32'h8001_1234;
    step();
    checks++;
    if ({rd_value_out, rd_writeback_out} !== {32'hFFFF_8001, 1'b1}) begin
      failures++;
      $display("FAIL priority_half_load: got val=%h wb=%b required ffff8001/1", rd_value_out, rd_writeback_out);
    end
  endtask

  task automatic test_reset_busy();
    idle_inputs();
    mem_read_en_in  = 1'b1;
    mem_width_in    = 2'd2;
    result_in       = 32'h0000_0080;
    rd_in           = 5'd12;
    rd_writeback_in = 1'b1;
    bus_ready_in    = 1'b0;
    step();
    idle_inputs();
    bus_ready_in = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_read_out, bus_write_out, stall_out, bus_address_out, rd_out, rd_writeback_out, rd_value_out} !== 73'd0) begin
      failures++;
      $display("FAIL reset_busy_outputs: got rd=%b wr=%b stall=%b addr=%h rd=%0d wb=%b val=%h required all 0",
               bus_read_out, bus_write_out, stall_out, bus_address_out, rd_out, rd_writeback_out, rd_value_out);
    end
    step();
    reset_n      = 1'b1;
    bus_ready_in = 1'b1;
    step();
    checks++;
    if ({rd_writeback_out, bus_read_out} !== 2'b00) begin
      failures++;
      $display("FAIL reset_busy_no_wb: got wb=%b rd=%b required 0/0", rd_writeback_out, bus_read_out);
    end
  endtask

`ifdef RV32_MEM_ALIGN_CHECK_EN
  task automatic test_misaligned();
    idle_inputs();
    mem_read_en_in  = 1'b1;
    mem_width_in    = 2'd2;
    result_in       = 32'h0000_0101;
    rd_in           = 5'd13;
    rd_writeback_in = 1'b1;
    step();
    checks++;
    if ({misaligned_out, bus_read_out, stall_out, rd_writeback_out} !== 4'b1000) begin
      failures++;
      $display("FAIL misaligned_pulse: got mis=%b rd=%b stall=%b wb=%b required 1/0/0/0",
               misaligned_out, bus_read_out, stall_out, rd_writeback_out);
    end
    idle_inputs();
    step();
    checks++;
    if (misaligned_out !== 1'b0) begin
      failures++;
      $display("FAIL misaligned_clear: got %b required 0", misaligned_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nonmem();
    test_byte_load(1'b0, 32'hFFFF_FF80);
    test_byte_load(1'b1, 32'h0000_0080);
    test_store(2'd1, 32'h0000_0202, 32'h0000_BEEF, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    test_store(2'd0, 32'h0000_0005, 32'h1234_5678, 32'h0000_0004, 4'b0010, 32'h7878_7878);
    test_word_load_wait();
    test_read_priority();
    test_reset_busy();
`ifdef RV32_MEM_ALIGN_CHECK_EN
    test_misaligned();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
